ps2_dev_tx: RTL and testbench
=============================

Name: ps2_dev_tx

Overview:
- Device-side PS/2 transmitter: the keyboard/mouse end of the PS/2 link that the SoC's cust_ps2 receiver samples.
- Used on FPGA builds to inject scan codes into cust_ps2_ps2_clk/dat without a physical keyboard.
- Buffers bytes in a small FIFO and serialises each one as an 11-bit PS/2 frame.
- Generates the PS/2 clock itself and honours host clock-inhibit.

Parameters:
- HALF_CYC, 4, clk_i cycles per PS/2 clock half-period (>=2); 2500 gives 10 kHz at 50 MHz.
- GAP_CYC, 16, idle clk_i cycles with both lines high between frames (>=1).
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- tx_valid_i  in  1  byte offered.
- tx_data_i  in  8  byte to send.
- tx_ready_o  out  1  FIFO not full; a byte is accepted when tx_valid_i & tx_ready_o.
- ps2_clk_i  in  1  sensed PS/2 clock line, asynchronous to clk_i; host pulls it low to inhibit.
- ps2_clk_o  out  1  PS/2 clock drive (1 = release/high).
- ps2_dat_o  out  1  PS/2 data drive (1 = release/high).
- busy_o  out  1  a frame is in progress.
- abort_o  out  1  one-cycle pulse when a frame is aborted by host inhibit.
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: ps2_clk_o=1, ps2_dat_o=1, busy_o=0, abort_o=0, fifo_cnt_o=0, tx_ready_o=1. FIFO is emptied; FSM enters IDLE.
- ps2_clk_i passes through a 2-flop synchroniser to give clk_s. Inhibit = clk_s==0 while ps2_clk_o==1.
- FIFO:
  - Push and pop in the same cycle are both legal; count is unchanged.
  - A push when full is impossible because tx_ready_o=0 when full.
  - The head entry is popped only after a frame completes.
- Frame: bit[0]=start 0; bit[1..8]=data LSB first; bit[9]=odd parity (~^data); bit[10]=stop 1.
- FSM IDLE:
  - Leaves for BIT with idx=0 when the FIFO is non-empty and inhibit has been clear for HALF_CYC consecutive cycles.
  - busy_o rises on the transition.
- FSM BIT (per bit):
  - HIGH phase: ps2_dat_o=bit[idx] and ps2_clk_o=1 for HALF_CYC cycles.
  - LOW phase: ps2_clk_o=0 for HALF_CYC cycles; data is held.
  - idx increments after the LOW phase. After idx=10 the FSM goes to GAP.
  - Data changes only at the start of a HIGH phase; the host samples on the falling edge.
- FSM GAP:
  - ps2_clk_o=1 and ps2_dat_o=1.
  - Pops the FIFO on entry (one cycle).
  - busy_o falls on entry.
  - Waits GAP_CYC cycles, then returns to IDLE.
- Abort:
  - Trigger: inhibit is detected during a HIGH phase with idx<=9.
  - Action: release both lines, pulse abort_o, do not pop, return to IDLE. The same byte is retransmitted from bit 0 after release.
  - Inhibit at idx=10 or later is ignored; the frame completes.
- Inhibit during a LOW phase is not detectable because the device itself is driving the line low, so it is ignored.
- Full frame latency with no inhibit: 22*HALF_CYC cycles from IDLE exit to GAP entry.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: PS2_DEV_TX_PAR_INJ_EN.
- When defined:
  - Adds input par_err_i (1 bit).
  - par_err_i is sampled on IDLE exit; if 1, the parity bit for that frame is inverted.
  - The sampled value is held for the frame, including its retransmission after an abort.
- When undefined: the port is absent and parity is always odd.

Test Plan:
- HALF_CYC=4, push 0x1C: ps2_dat_o sequence over HIGH phases = 0,0,0,1,1,1,0,0,0,0,1; 11 falling edges of ps2_clk_o; busy_o high for 88 cycles.
- Push 0x00 then 0xFF back-to-back: parity bits 1 then 1; frames separated by at least GAP_CYC=16 idle-high cycles; fifo_cnt_o goes 2 -> 1 -> 0.
- Push 5 bytes with FIFO_DEPTH=4 and no pops: tx_ready_o=0 after the 4th accept (one byte already in flight is popped later); all bytes are sent in order.
- Hold ps2_clk_i low in IDLE with the FIFO non-empty: no transmission. Release: the frame starts exactly HALF_CYC cycles after clk_s rises.
- Pull ps2_clk_i low during the HIGH phase of idx=4 of byte 0xE0: abort_o pulses once and both lines go high. After release, 0xE0 is resent in full; fifo_cnt_o is unchanged until completion.
- With PS2_DEV_TX_PAR_INJ_EN defined and par_err_i=1, send 0x1C: parity bit = 1. With par_err_i=0: parity bit = 0.

Source files
------------

// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter: byte FIFO feeding an 11-bit frame serialiser that honours host inhibit.
// Optional parity-error injection is enabled by defining PS2_DEV_TX_PAR_INJ_EN (adds par_err_i).

module ps2_dev_tx #(
    parameter int unsigned HALF_CYC   = 4,
    parameter int unsigned GAP_CYC    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        tx_valid_i,
    input  logic [7:0]                  tx_data_i,
    output logic                        tx_ready_o,
    input  logic                        ps2_clk_i,
    output logic                        ps2_clk_o,
    output logic                        ps2_dat_o,
    output logic                        busy_o,
    output logic                        abort_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
`ifdef PS2_DEV_TX_PAR_INJ_EN
    ,
    input  logic                        par_err_i
`endif
);

    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned TMAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [TW-1:0] clr_cnt, clr_nxt;
    logic [3:0]    idx, idx_nxt;
    logic          clk_nxt, dat_nxt, busy_nxt;
    logic          clk_meta, clk_s, clk_o_d1, clk_o_d2;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic          push_c, pop_c, abort_c, inhibit_c;
    logic [7:0]    head_c;
    logic [10:0]   frame_c;
    logic          par_inj;

`ifdef PS2_DEV_TX_PAR_INJ_EN
    logic          par_nxt, retry, retry_nxt;
`else
    assign par_inj = 1'b0;
`endif

    // Our own low drive is still visible through the synchroniser for two cycles; mask it.
    assign inhibit_c = ~clk_s & ps2_clk_o & clk_o_d1 & clk_o_d2;

    assign push_c  = tx_valid_i & tx_ready_o;
    assign cnt_nxt = fifo_cnt_o + CW'(push_c) - CW'(pop_c);
    assign head_c  = mem[rd_ptr];
    assign frame_c = {1'b1, (~^head_c) ^ par_inj, head_c, 1'b0};

    // FIFO storage, no reset needed.
    always_ff @(posedge clk_i) begin
        if (push_c) mem[wr_ptr] <= tx_data_i;
    end

    // State, FIFO pointers, synchroniser and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tmr        <= '0;
            clr_cnt    <= '0;
            idx        <= '0;
            clk_meta   <= 1'b1;
            clk_s      <= 1'b1;
            clk_o_d1   <= 1'b1;
            clk_o_d2   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
            tx_ready_o <= 1'b1;
            ps2_clk_o  <= 1'b1;
            ps2_dat_o  <= 1'b1;
            busy_o     <= 1'b0;
            abort_o    <= 1'b0;
`ifdef PS2_DEV_TX_PAR_INJ_EN
            par_inj    <= 1'b0;
            retry      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            clr_cnt    <= clr_nxt;
            idx        <= idx_nxt;
            clk_meta   <= ps2_clk_i;
            clk_s      <= clk_meta;
            clk_o_d1   <= ps2_clk_o;
            clk_o_d2   <= clk_o_d1;
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt_o <= cnt_nxt;
            tx_ready_o <= (cnt_nxt != CW'(FIFO_DEPTH));
            ps2_clk_o  <= clk_nxt;
            ps2_dat_o  <= dat_nxt;
            busy_o     <= busy_nxt;
            abort_o    <= abort_c;
`ifdef PS2_DEV_TX_PAR_INJ_EN
            par_inj    <= par_nxt;
            retry      <= retry_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + TW'(1);
        clr_nxt   = '0;
        idx_nxt   = idx;
        pop_c     = 1'b0;
        abort_c   = 1'b0;
        clk_nxt   = 1'b1;
        dat_nxt   = 1'b1;
        busy_nxt  = 1'b0;
`ifdef PS2_DEV_TX_PAR_INJ_EN
        par_nxt   = par_inj;
        retry_nxt = retry;
`endif
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (!inhibit_c)
                    clr_nxt = (clr_cnt == TW'(HALF_CYC)) ? clr_cnt : clr_cnt + TW'(1);
                if (!inhibit_c && clr_cnt >= TW'(HALF_CYC - 1) && fifo_cnt_o != '0) begin
                    state_nxt = HIGH;
                    idx_nxt   = '0;
`ifdef PS2_DEV_TX_PAR_INJ_EN
                    if (!retry) par_nxt = par_err_i;
`endif
                end
            end
            HIGH: begin
                if (inhibit_c && idx <= 4'd9) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                    abort_c   = 1'b1;
`ifdef PS2_DEV_TX_PAR_INJ_EN
                    retry_nxt = 1'b1;
`endif
                end else if (tmr == TW'(HALF_CYC - 1)) begin
                    state_nxt = LOW;
                    tmr_nxt   = '0;
                end
            end
            LOW: begin
                if (tmr == TW'(HALF_CYC - 1)) begin
                    tmr_nxt = '0;
                    if (idx == 4'd10) begin
                        state_nxt = GAP;
                        pop_c     = 1'b1;
`ifdef PS2_DEV_TX_PAR_INJ_EN
                        retry_nxt = 1'b0;
`endif
                    end else begin
                        state_nxt = HIGH;
                        idx_nxt   = idx + 4'd1;
                    end
                end
            end
            GAP: begin
                if (tmr == TW'(GAP_CYC - 1)) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == HIGH) || (state_nxt == LOW);
        clk_nxt  = (state_nxt != LOW);
        dat_nxt  = busy_nxt ? frame_c[idx_nxt] : 1'b1;
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx: a frame monitor decodes the PS/2 lines and checks them against a scoreboard.

module tb_ps2_dev_tx;

    localparam int unsigned HALF_CYC   = 4;
    localparam int unsigned GAP_CYC    = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

    typedef struct {
        logic [7:0] data;
        logic       flip;
    } exp_t;

    logic          clk_i      = 1'b0;
    logic          rst_i      = 1'b1;
    logic          tx_valid_i = 1'b0;
    logic [7:0]    tx_data_i  = 8'h00;
    logic          host_clk   = 1'b1;
    logic          tx_ready_o;
    logic          ps2_clk_i;
    logic          ps2_clk_o;
    logic          ps2_dat_o;
    logic          busy_o;
    logic          abort_o;
    logic [CW-1:0] fifo_cnt_o;
`ifdef PS2_DEV_TX_PAR_INJ_EN
    logic          par_err_i  = 1'b0;
`endif

    // Wired-AND bus: the sensed clock is low if either side pulls it low.
    assign ps2_clk_i = host_clk & ps2_clk_o;

    ps2_dev_tx #(
        .HALF_CYC  (HALF_CYC),
        .GAP_CYC   (GAP_CYC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tx_valid_i(tx_valid_i),
        .tx_data_i (tx_data_i),
        .tx_ready_o(tx_ready_o),
        .ps2_clk_i (ps2_clk_i),
        .ps2_clk_o (ps2_clk_o),
        .ps2_dat_o (ps2_dat_o),
        .busy_o    (busy_o),
        .abort_o   (abort_o),
        .fifo_cnt_o(fifo_cnt_o)
`ifdef PS2_DEV_TX_PAR_INJ_EN
        ,
        .par_err_i (par_err_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    int          nbits = 0, frames = 0, n_falls = 0, n_abort = 0, n_busy = 0, gap_cnt = 0;
    bit          have_prev = 1'b0, prev_ck = 1'b1;
    logic [10:0] shreg = '0, last_frame = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame monitor, sampled on the falling clk_i edge.
    task automatic mon_step();
        exp_t e;
        if (rst_i) begin
            nbits = 0; have_prev = 1'b0; gap_cnt = 0;
        end else if (abort_o) begin
            nbits = 0; have_prev = 1'b0; n_abort++;
        end else if (prev_ck && !ps2_clk_o) begin
            if (nbits == 0 && have_prev) chk("frame_gap", 32'(gap_cnt >= int'(GAP_CYC)), 1);
            shreg[nbits] = ps2_dat_o;
            nbits++;
            n_falls++;
            if (nbits == 11) begin
                nbits = 0; frames++; last_frame = shreg; have_prev = 1'b1; gap_cnt = 0;
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("frame", 32'(shreg), 32'({1'b1, (~^e.data) ^ e.flip, e.data, 1'b0}));
                end
            end
        end
        if (ps2_clk_o && ps2_dat_o && !busy_o) gap_cnt++;
        if (busy_o) n_busy++;
        prev_ck = ps2_clk_o;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic flip);
        int g = 0;
        tx_valid_i = 1'b1;
        tx_data_i  = b;
        while (!tx_ready_o && g < 3000) begin cyc(1); g++; end
        chk("push_ready", 32'(tx_ready_o), 1);
        cyc(1);
        tx_valid_i = 1'b0;
        exp_q.push_back('{b, flip});
    endtask

    task automatic wait_frames(input int target);
        int g = 0;
        while (frames < target && g < 5000) begin cyc(1); g++; end
        chk("frame_timeout", 32'(frames >= target), 1);
    endtask

    task automatic wait_not_busy();
        int g = 0;
        while (busy_o && g < 1000) begin cyc(1); g++; end
        chk("busy_timeout", 32'(busy_o), 0);
    endtask

    initial begin
        int base_f, base_falls, base_busy, base_ab, k;
        fork
            forever @(negedge clk_i) mon_step();
        join_none

        // Reset values
        cyc(3);
        chk("rst_clk", 32'(ps2_clk_o), 1);
        chk("rst_dat", 32'(ps2_dat_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_abort", 32'(abort_o), 0);
        chk("rst_cnt", 32'(fifo_cnt_o), 0);
        chk("rst_ready", 32'(tx_ready_o), 1);
        rst_i = 1'b0;
        cyc(2);

        // Single frame 0x1C
        base_falls = n_falls; base_busy = n_busy;
        push(8'h1C, 1'b0);
        wait_frames(1);
        chk("f1c_bits", 32'(last_frame), 32'h438);
        chk("f1c_falls", 32'(n_falls - base_falls), 11);
        wait_not_busy();
        chk("f1c_busy_cycles", 32'(n_busy - base_busy), 22 * HALF_CYC);
        chk("f1c_cnt", 32'(fifo_cnt_o), 0);
        cyc(GAP_CYC + 4);

        // 0x00 then 0xFF back-to-back
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        chk("b2b_cnt2", 32'(fifo_cnt_o), 2);
        wait_frames(2);
        chk("par_00", 32'(last_frame[9]), 1);
        wait_not_busy();
        chk("b2b_cnt1", 32'(fifo_cnt_o), 1);
        wait_frames(3);
        chk("par_ff", 32'(last_frame[9]), 1);
        wait_not_busy();
        chk("b2b_cnt0", 32'(fifo_cnt_o), 0);
        cyc(GAP_CYC + 4);

        // Five bytes into a four-deep FIFO
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b0);
        push(8'h81, 1'b0);
        push(8'h7E, 1'b0);
        chk("full_ready", 32'(tx_ready_o), 0);
        chk("full_cnt", 32'(fifo_cnt_o), 4);
        push(8'h12, 1'b0);
        wait_frames(8);
        wait_not_busy();
        chk("five_cnt0", 32'(fifo_cnt_o), 0);
        chk("five_sb_empty", 32'(exp_q.size()), 0);
        cyc(GAP_CYC + 4);

        // Inhibit held in IDLE, then release
        host_clk = 1'b0;
        base_falls = n_falls;
        push(8'h5A, 1'b0);
        cyc(100);
        chk("inh_busy", 32'(busy_o), 0);
        chk("inh_falls", 32'(n_falls - base_falls), 0);
        chk("inh_cnt", 32'(fifo_cnt_o), 1);
        host_clk = 1'b1;
        k = 0;
        while (!busy_o && k < 100) begin cyc(1); k++; end
        chk("inh_release_lat", 32'(k), HALF_CYC + 2);
        wait_frames(9);
        wait_not_busy();
        cyc(GAP_CYC + 4);

        // Abort during the HIGH phase of idx=4 of 0xE0
        base_ab = n_abort; base_f = frames;
        push(8'hE0, 1'b0);
        k = 0;
        while (!(nbits == 4 && ps2_clk_o) && k < 500) begin cyc(1); k++; end
        chk("abort_reach_idx4", 32'(nbits), 4);
        host_clk = 1'b0;
        cyc(30);
        chk("abort_pulses", 32'(n_abort - base_ab), 1);
        chk("abort_clk", 32'(ps2_clk_o), 1);
        chk("abort_dat", 32'(ps2_dat_o), 1);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_cnt", 32'(fifo_cnt_o), 1);
        host_clk = 1'b1;
        wait_frames(base_f + 1);
        chk("retx_cnt_held", 32'(fifo_cnt_o), 1);
        wait_not_busy();
        chk("retx_cnt0", 32'(fifo_cnt_o), 0);
        chk("retx_one_abort", 32'(n_abort - base_ab), 1);
        cyc(GAP_CYC + 4);

`ifdef PS2_DEV_TX_PAR_INJ_EN
        // Parity injection
        par_err_i = 1'b1;
        push(8'h1C, 1'b1);
        wait_frames(frames + 1);
        chk("inj_par1", 32'(last_frame[9]), 1);
        wait_not_busy();
        par_err_i = 1'b0;
        cyc(GAP_CYC + 4);
        push(8'h1C, 1'b0);
        wait_frames(frames + 1);
        chk("inj_par0", 32'(last_frame[9]), 0);
        wait_not_busy();
        cyc(GAP_CYC + 4);
`endif

        // Reset mid-frame: partial frame lost
        base_f = frames;
        push(8'h55, 1'b0);
        k = 0;
        while (nbits < 3 && k < 500) begin cyc(1); k++; end
        rst_i = 1'b1;
        #1;
        chk("mid_rst_clk", 32'(ps2_clk_o), 1);
        chk("mid_rst_dat", 32'(ps2_dat_o), 1);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_cnt", 32'(fifo_cnt_o), 0);
        chk("mid_rst_ready", 32'(tx_ready_o), 1);
        @(negedge clk_i);
        cyc(1);
        rst_i = 1'b0;
        exp_q.delete();
        base_falls = n_falls;
        cyc(150);
        chk("post_rst_idle", 32'(busy_o), 0);
        chk("post_rst_falls", 32'(n_falls - base_falls), 0);
        chk("post_rst_frames", 32'(frames - base_f), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
